// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fp_pkg
//  Brief    : Shared FP32 constants, sequencer state encoding and a
//             leading-zero counter used by the add/subtract core.
//  Revision : 1.0 - initial release
// ============================================================================
package fp_pkg;

    localparam int          FP_W     = 32;
    localparam logic [31:0] FP_ZERO  = 32'h0000_0000;
    localparam logic [31:0] FP_NZERO = 32'h8000_0000;
    localparam logic [31:0] FP_INF   = 32'h7F80_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Number of leading zeros in a 24-bit significand (24 when all zero).
    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        n = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (v[i]) begin
                n = 5'(23 - i);
            end
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/Addition_Subtraction.sv
`default_nettype none
// ============================================================================
//  Module   : Addition_Subtraction
//  Brief    : Combinational IEEE-754 single add/subtract. Truncating, with
//             subnormal inputs and underflowing results flushed to zero. Any
//             operand with exponent 255 raises Exception and returns +0.
//  Revision : 1.0 - initial release
// ============================================================================
module Addition_Subtraction (
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    input  logic        AddBar_Sub,
    output logic        Exception,
    output logic [31:0] result
);
    import fp_pkg::*;

    logic        w_b_sign;
    logic        w_swap;
    logic        w_eff_sub;
    logic [31:0] w_big;
    logic [31:0] w_small;
    logic [7:0]  w_big_e;
    logic [7:0]  w_small_e;
    logic [7:0]  w_diff;
    logic [23:0] w_big_m;
    logic [23:0] w_small_m;
    logic [23:0] w_small_al;
    logic [24:0] w_sum;
    logic [23:0] w_dif;
    logic [4:0]  w_lz;
    logic [23:0] w_norm;

    // Subtraction is addition with B's sign flipped; order by magnitude so
    // the larger operand sets the exponent and the result sign.
    assign w_b_sign   = b_operand[31] ^ AddBar_Sub;
    assign w_swap     = b_operand[30:0] > a_operand[30:0];
    assign w_big      = w_swap ? {w_b_sign, b_operand[30:0]} : a_operand;
    assign w_small    = w_swap ? a_operand : {w_b_sign, b_operand[30:0]};
    assign w_eff_sub  = w_big[31] ^ w_small[31];

    assign w_big_e    = w_big[30:23];
    assign w_small_e  = w_small[30:23];
    assign w_big_m    = (|w_big_e)   ? {1'b1, w_big[22:0]}   : 24'd0;
    assign w_small_m  = (|w_small_e) ? {1'b1, w_small[22:0]} : 24'd0;
    assign w_diff     = w_big_e - w_small_e;
    assign w_small_al = (w_diff > 8'd23) ? 24'd0 : (w_small_m >> w_diff);

    assign w_sum      = {1'b0, w_big_m} + {1'b0, w_small_al};
    assign w_dif      = w_big_m - w_small_al;
    assign w_lz       = lzc24(w_dif);
    assign w_norm     = w_dif << w_lz;

    assign Exception  = (&a_operand[30:23]) | (&b_operand[30:23]);

    // Assemble the result: carry renormalisation for additions, leading-zero
    // renormalisation for effective subtractions.
    always_comb begin
        result = FP_ZERO;
        if (Exception || (w_big_m == 24'd0)) begin
            result = FP_ZERO;
        end else if (!w_eff_sub) begin
            if (w_sum[24]) begin
                if (w_big_e == 8'd254) begin
                    result = {w_big[31], FP_INF[30:0]};
                end else begin
                    result = {w_big[31], w_big_e + 8'd1, w_sum[23:1]};
                end
            end else begin
                result = {w_big[31], w_big_e, w_sum[22:0]};
            end
        end else begin
            if (!w_norm[23] || ({3'b000, w_lz} >= w_big_e)) begin
                result = FP_ZERO;
            end else begin
                result = {w_big[31], w_big_e - {3'b000, w_lz}, w_norm[22:0]};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Brief    : Combinational round-robin pick: first valid requester at or
//             above rr_ptr, wrapping to the lowest index below it.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDW-1:0]     rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_idx,
    output logic               grant_any
);
    logic           w_hit_hi;
    logic           w_hit_lo;
    logic [IDW-1:0] w_idx_hi;
    logic [IDW-1:0] w_idx_lo;

    // Lowest valid index in the upper (>= rr_ptr) and lower (< rr_ptr) halves.
    always_comb begin
        w_hit_hi = 1'b0;
        w_hit_lo = 1'b0;
        w_idx_hi = '0;
        w_idx_lo = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (IDW'(i) >= rr_ptr) begin
                    w_hit_hi = 1'b1;
                    w_idx_hi = IDW'(i);
                end else begin
                    w_hit_lo = 1'b1;
                    w_idx_lo = IDW'(i);
                end
            end
        end
    end

    assign grant_any = w_hit_hi | w_hit_lo;
    assign grant_idx = w_hit_hi ? w_idx_hi : w_idx_lo;
    assign grant     = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/fp_addsub_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fp_addsub_arbiter
//  Brief    : Shares one FP32 add/subtract core between NUM_REQ requesters
//             with round-robin grant and one operation in flight.
//  Revision : 1.0 - initial release
// ============================================================================
module fp_addsub_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ),
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    input  logic [NUM_REQ-1:0]    req_sub,
    output logic [NUM_REQ-1:0]    rsp_valid,
    input  logic [NUM_REQ-1:0]    rsp_ready,
    output logic [31:0]           rsp_result,
    output logic                  rsp_exception,
    output logic                  busy,
    output logic [CNT_W-1:0]      exc_count
);
    import fp_pkg::*;

    arb_state_t     r_state;
    arb_state_t     w_state_nxt;
    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] r_owner;
    logic [IDW-1:0] w_grant_idx;
    logic [NUM_REQ-1:0] w_grant;
    logic           w_grant_any;
    logic           w_req_hs;
    logic           w_rsp_hs;
    logic [FP_W-1:0] w_sel_a;
    logic [FP_W-1:0] w_sel_b;
    logic           w_sel_sub;
    logic [FP_W-1:0] r_op_a;
    logic [FP_W-1:0] r_op_b;
    logic           r_op_sub;
    logic [FP_W-1:0] w_core_result;
    logic           w_core_exc;
    logic [FP_W-1:0] r_rsp_result;
    logic           r_rsp_exception;
    logic [CNT_W-1:0] r_exc_count;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_arbiter (
        .req_valid (req_valid),
        .rr_ptr    (r_rr_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .grant_any (w_grant_any)
    );

    Addition_Subtraction u_core (
        .a_operand  (r_op_a),
        .b_operand  (r_op_b),
        .AddBar_Sub (r_op_sub),
        .Exception  (w_core_exc),
        .result     (w_core_result)
    );

    // A grant always targets a valid requester, so a grant in IDLE is the handshake.
    assign req_ready     = (r_state == IDLE) ? w_grant : '0;
    assign w_req_hs      = (r_state == IDLE) && w_grant_any;
    assign rsp_valid     = (r_state == RESP) ? (NUM_REQ'(1) << r_owner) : '0;
    assign w_rsp_hs      = |(rsp_valid & rsp_ready);
    assign busy          = (r_state != IDLE);
    assign rsp_result    = r_rsp_result;
    assign rsp_exception = r_rsp_exception;
    assign exc_count     = r_exc_count;

    // Select the granted requester's operands (grant is one-hot or zero).
    always_comb begin
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_sub = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_a   = req_a[i*FP_W +: FP_W];
                w_sel_b   = req_b[i*FP_W +: FP_W];
                w_sel_sub = req_sub[i];
            end
        end
    end

    // Next-state logic: accept -> compute for one cycle -> hold response.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_req_hs) w_state_nxt = CALC;
            CALC:    w_state_nxt = RESP;
            RESP:    if (w_rsp_hs) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Arbitration pointer and owner: pointer moves past the owner on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
            r_owner  <= '0;
        end else begin
            if (w_req_hs) begin
                r_owner <= w_grant_idx;
            end
            if ((r_state == RESP) && w_rsp_hs) begin
                r_rr_ptr <= (r_owner == IDW'(NUM_REQ - 1)) ? '0 : r_owner + IDW'(1);
            end
        end
    end

    // Operand capture on accept; result capture and exception count in CALC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a          <= FP_ZERO;
            r_op_b          <= FP_ZERO;
            r_op_sub        <= 1'b0;
            r_rsp_result    <= FP_ZERO;
            r_rsp_exception <= 1'b0;
            r_exc_count     <= '0;
        end else begin
            if (w_req_hs) begin
                r_op_a   <= w_sel_a;
                r_op_b   <= w_sel_b;
                r_op_sub <= w_sel_sub;
            end
            if (r_state == CALC) begin
                r_rsp_result    <= w_core_result;
                r_rsp_exception <= w_core_exc;
                if (w_core_exc && !(&r_exc_count)) begin
                    r_exc_count <= r_exc_count + CNT_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_addsub_arbiter
//  Brief    : Directed, table-driven bench for fp_addsub_arbiter, with a
//             second narrow-counter instance for counter saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fp_addsub_arbiter;

    localparam int NR = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [NR-1:0]   req_valid, req_ready, req_sub, rsp_valid, rsp_ready;
    logic [NR*32-1:0] req_a, req_b;
    logic [31:0]     rsp_result;
    logic            rsp_exception, busy;
    logic [15:0]     exc_count;

    logic [1:0]      s_req_valid, s_req_ready, s_req_sub, s_rsp_valid, s_rsp_ready;
    logic [63:0]     s_req_a, s_req_b;
    logic [31:0]     s_rsp_result;
    logic            s_rsp_exception, s_busy;
    logic [1:0]      s_exc_count;

    fp_addsub_arbiter #(.NUM_REQ(NR), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_exception(rsp_exception),
        .busy(busy), .exc_count(exc_count)
    );

    fp_addsub_arbiter #(.NUM_REQ(2), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst_n(rst_n),
        .req_valid(s_req_valid), .req_ready(s_req_ready),
        .req_a(s_req_a), .req_b(s_req_b), .req_sub(s_req_sub),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready),
        .rsp_result(s_rsp_result), .rsp_exception(s_rsp_exception),
        .busy(s_busy), .exc_count(s_exc_count)
    );

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    vec_t vecs[12];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_ptr   = 0;
    int   m_exc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Single operation on requester idx, called and returning at a negedge.
    task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic [31:0] er, input logic ee,
                          input string tag);
        int k;
        req_a[idx*32 +: 32] = a;
        req_b[idx*32 +: 32] = b;
        req_sub[idx]        = sub;
        req_valid[idx]      = 1'b1;
        rsp_ready           = '1;
        #1;
        k = 0;
        while (!req_ready[idx] && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({tag, " grant"}, 32'(req_ready), 32'(1) << idx);
        @(negedge clk);
        req_valid[idx] = 1'b0;
        check({tag, " calc busy"}, 32'(busy), 32'd1);
        check({tag, " calc rsp_valid"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'(1) << idx);
        check({tag, " result"}, rsp_result, er);
        check({tag, " exception"}, 32'(rsp_exception), 32'(ee));
        @(negedge clk);
        check({tag, " idle"}, 32'(busy), 32'd0);
        m_ptr = (idx + 1) % NR;
    endtask

    initial begin
        vecs[0]  = '{0, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 1'b0}; // 1+2
        vecs[1]  = '{2, 32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, 1'b0}; // 3-1
        vecs[2]  = '{1, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b0}; // 1+1
        vecs[3]  = '{3, 32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 1'b0}; // 1-1
        vecs[4]  = '{0, 32'h4000_0000, 32'hBF80_0000, 1'b0, 32'h3F80_0000, 1'b0}; // 2+(-1)
        vecs[5]  = '{1, 32'h3F80_0000, 32'h4000_0000, 1'b1, 32'hBF80_0000, 1'b0}; // 1-2
        vecs[6]  = '{2, 32'h3FC0_0000, 32'h3F00_0000, 1'b0, 32'h4000_0000, 1'b0}; // 1.5+0.5
        vecs[7]  = '{3, 32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h0000_0000, 1'b1}; // inf+1
        vecs[8]  = '{0, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 32'h0000_0000, 1'b1}; // 1+NaN
        vecs[9]  = '{1, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0}; // 0+0
        vecs[10] = '{2, 32'hC000_0000, 32'hBF80_0000, 1'b0, 32'hC040_0000, 1'b0}; // -2+-1
        vecs[11] = '{3, 32'h40A0_0000, 32'h4040_0000, 1'b1, 32'h4000_0000, 1'b0}; // 5-3

        rst_n = 1'b0;
        req_valid = '0; req_sub = '0; rsp_ready = '0; req_a = '0; req_b = '0;
        s_req_valid = '0; s_req_sub = '0; s_rsp_ready = '0; s_req_a = '0; s_req_b = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset req_ready", 32'(req_ready), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset result", rsp_result, 32'd0);
        check("reset exception", 32'(rsp_exception), 32'd0);
        check("reset exc_count", 32'(exc_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table of single operations.
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].sub,
                   vecs[i].res, vecs[i].exc, $sformatf("vec%0d", i));
            if (vecs[i].exc) m_exc++;
        end
        check("exc_count after table", 32'(exc_count), 32'(m_exc));

        // Round-robin with every requester holding valid (1.0 + 1.0 each).
        for (int r = 0; r < NR; r++) begin
            req_a[r*32 +: 32] = 32'h3F80_0000;
            req_b[r*32 +: 32] = 32'h3F80_0000;
            req_sub[r]        = 1'b0;
        end
        rsp_ready = '1;
        req_valid = '1;
        #1;
        begin
            int prev;
            prev = -1;
            for (int n = 0; n < 12; n++) begin
                int k;
                k = 0;
                while (req_ready == '0 && k < 20) begin
                    @(negedge clk);
                    k++;
                end
                check($sformatf("rr%0d grant", n), 32'(req_ready), 32'(1) << m_ptr);
                n_tests++;
                if (m_ptr == prev) begin
                    n_fail++;
                    $display("FAIL rr%0d repeat: got grant %0d twice, required a different requester", n, m_ptr);
                end
                prev = m_ptr;
                @(negedge clk);
                @(negedge clk);
                check($sformatf("rr%0d rsp_valid", n), 32'(rsp_valid), 32'(1) << m_ptr);
                check($sformatf("rr%0d result", n), rsp_result, 32'h4000_0000);
                m_ptr = (m_ptr + 1) % NR;
                @(negedge clk);
            end
        end
        req_valid = '0;

        // Backpressure on requester 1 while requester 3 waits.
        req_a[1*32 +: 32] = 32'h4040_0000;
        req_b[1*32 +: 32] = 32'h3F80_0000;
        req_sub[1]        = 1'b1;
        rsp_ready         = 4'b1101;
        req_valid[1]      = 1'b1;
        #1;
        check("bp grant", 32'(req_ready), 32'b0010);
        @(negedge clk);
        req_valid[1] = 1'b0;
        req_valid[3] = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp%0d rsp_valid", c), 32'(rsp_valid), 32'b0010);
            check($sformatf("bp%0d result", c), rsp_result, 32'h4000_0000);
            check($sformatf("bp%0d req_ready", c), 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready[1] = 1'b1;
        #1;
        check("bp complete req_ready", 32'(req_ready), 32'd0);
        check("bp complete rsp_valid", 32'(rsp_valid), 32'b0010);
        @(negedge clk);
        check("bp idle busy", 32'(busy), 32'd0);
        check("bp next grant", 32'(req_ready), 32'b1000);
        req_valid = '0;
        @(negedge clk);

        // Counter saturation on the narrow-counter instance.
        for (int e = 0; e < 4; e++) begin
            int k;
            s_req_a[31:0]  = 32'h7F80_0000;
            s_req_b[31:0]  = 32'h3F80_0000;
            s_req_sub[0]   = 1'b0;
            s_rsp_ready    = 2'b11;
            s_req_valid[0] = 1'b1;
            #1;
            k = 0;
            while (!s_req_ready[0] && k < 20) begin
                @(negedge clk);
                k++;
            end
            check($sformatf("sat%0d grant", e), 32'(s_req_ready), 32'b01);
            @(negedge clk);
            s_req_valid[0] = 1'b0;
            @(negedge clk);
            check($sformatf("sat%0d exception", e), 32'(s_rsp_exception), 32'd1);
            check($sformatf("sat%0d result", e), s_rsp_result, 32'd0);
            @(negedge clk);
            check($sformatf("sat%0d exc_count", e), 32'(s_exc_count), (e < 3) ? 32'(e + 1) : 32'd3);
        end

        // Reset while requester 2's operation is in CALC.
        req_a[2*32 +: 32] = 32'h7F80_0000;
        req_b[2*32 +: 32] = 32'h3F80_0000;
        req_sub[2]        = 1'b0;
        rsp_ready         = '1;
        req_valid[2]      = 1'b1;
        #1;
        check("rst grant", 32'(req_ready), 32'b0100);
        @(negedge clk);
        check("rst in calc", 32'(busy), 32'd1);
        rst_n     = 1'b0;
        req_valid = '0;
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst req_ready", 32'(req_ready), 32'd0);
        check("rst result", rsp_result, 32'd0);
        check("rst exception", 32'(rsp_exception), 32'd0);
        check("rst exc_count", 32'(exc_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("post-rst%0d rsp_valid", c), 32'(rsp_valid), 32'd0);
        end
        req_valid = '1;
        #1;
        check("post-rst first grant", 32'(req_ready), 32'b0001);
        req_valid = '0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_addsub_arbiter.md
# fp_addsub_arbiter

Sequencer that shares one combinational FP32 add/subtract core (`Addition_Subtraction`) between `NUM_REQ` requesters. Each requester offers an operand pair and an add/sub flag on a valid/ready channel. A round-robin arbiter grants one request at a time and registers the operands into the core. The block registers the core's result and exception flag and returns them on a per-requester response handshake. It sits between the FP scheduling logic and the shared arithmetic datapath, with exactly one operation in flight.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `IDW`, default `$clog2(NUM_REQ)`: width of the granted-requester index.
- `CNT_W`, default 16: width of the saturating exception counter.

- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req_valid`  in  `NUM_REQ`: per-requester request valid.
- `req_ready`  out  `NUM_REQ`: per-requester accept; one-hot or zero.
- `req_a`  in  `NUM_REQ*32`: operand A, IEEE-754 single; requester i occupies bits [32i+31:32i].
- `req_b`  in  `NUM_REQ*32`: operand B, same packing.
- `req_sub`  in  `NUM_REQ`: 1 = A−B, 0 = A+B.
- `rsp_valid`  out  `NUM_REQ`: response valid, one-hot or zero.
- `rsp_ready`  in  `NUM_REQ`: per-requester response accept.
- `rsp_result`  out  32: result of the current response (shared bus).
- `rsp_exception`  out  1: core exception flag (either operand exponent = 255).
- `busy`  out  1: high when state ≠ IDLE.
- `exc_count`  out  `CNT_W`: saturating count of completed operations with exception = 1.

## Operation
- FSM states: IDLE, CALC, RESP.
- **IDLE**
  - If any `req_valid` is high, pick the winner: the first set bit at or above `rr_ptr`, scanning upward with wrap.
  - Drive `req_ready[winner]=1` combinationally; all other `req_ready` bits are 0.
  - On the handshake, latch `req_a`/`req_b`/`req_sub` of the winner into the operand registers, latch `owner=winner`, go to CALC.
  - `req_ready` is 0 in every other state.
- **CALC**
  - The core sees only the registered operands.
  - Register the core's `result` into `rsp_result` and `Exception` into `rsp_exception`.
  - If `Exception`=1 and `exc_count` is not all-ones, increment `exc_count`.
  - Go to RESP.
- **RESP**
  - Hold `rsp_valid[owner]=1` with `rsp_result`/`rsp_exception` stable until `rsp_ready[owner]`.
  - On that handshake: set `rr_ptr = owner+1`, wrapping at `NUM_REQ`; go to IDLE.
  - `rsp_ready` bits of non-owners are ignored.
- The arbiter is fair: every requester holding `req_valid` is served within `NUM_REQ` grants.
- A requester dropping `req_valid` before being granted is legal; nothing is latched for it.
- Operand registers, `rsp_result` and `rsp_exception` hold their values outside their load cycles.

## Timing
- Request handshake at cycle T → `rsp_valid` high from T+2.
- Minimum issue interval is 3 cycles (`rsp_ready` already high at T+2 → next grant at T+3).
- If `rsp_ready` is high in the same cycle `rsp_valid` rises, the response completes that cycle.
- A new request is never accepted in the cycle a response completes.
- Reset values:
  - state IDLE, `rr_ptr`=0, `owner`=0.
  - Operand registers 0; `rsp_result`=0, `rsp_exception`=0, `exc_count`=0.
  - `req_ready`=0, `rsp_valid`=0, `busy`=0.
- Reset asserted mid-operation discards the in-flight operation; no response is produced after reset.
- `exc_count` holds at 2^`CNT_W`−1 once saturated.

## Structure
- Shared package `fp_pkg`:
  - `FP_W=32`.
  - Constants `FP_ZERO=32'h0000_0000`, `FP_NZERO=32'h8000_0000`, `FP_INF=32'h7F80_0000`.
  - State enum `arb_state_t` {IDLE, CALC, RESP}.
- Sub-module `rr_arbiter` (parameter `NUM_REQ`): purely combinational one-hot grant from `req_valid` and `rr_ptr`, plus encoded index output.
- One `Addition_Subtraction` instance, fed only from the operand registers.

## Test plan
- **Single add:** req0 with A=0x3F800000, B=0x40000000, sub=0 → `rsp_valid[0]` at T+2, result 0x40400000, exception 0.
- **Single sub:** req2 with A=0x40400000, B=0x3F800000, sub=1 → result 0x40000000 on `rsp_valid[2]`.
- **Round-robin:** all four requesters hold `req_valid` for 12 operations → grant order 0,1,2,3,0,1,2,3,…; no requester is granted twice in a row.
- **Backpressure:** hold `rsp_ready[1]=0` for 5 cycles → `rsp_valid[1]` and result stay stable; `req_ready` stays 0; IDLE returns the cycle after `rsp_ready[1]` rises.
- **Exception:** A=0x7F800000, B=0x3F800000 → result 0x00000000, `rsp_exception`=1, `exc_count` 0→1. Preload the counter to 0xFFFF and repeat → `exc_count` stays 0xFFFF.
- **Reset mid-operation:** pull `rst_n` low in CALC → all outputs at reset values immediately; no `rsp_valid` after release; the next grant starts from requester 0.
